bit_shift_ctrl: RTL and testbench
=================================

# bit_shift_ctrl

Button-driven 8-bit shift register for the button/LED virtual interface prototype. Each new press of one of two dedicated buttons moves the LED pattern one position left or right. A shift that would push a set bit off the end is suppressed, so the pattern stops at the edge. The `bits` output drives the LED row directly; the remaining button inputs are reserved and ignored.

## Interface

Parameters:
- `START_BITS`, default `8'b00011000`: pattern loaded into `bits` on reset.

Ports:
- `clk`, input, 1: single system clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `buttons`, input, 24: raw button levels from the virtual interface.
  - `buttons[0]` = shift right (toward LSB).
  - `buttons[1]` = shift left (toward MSB).
  - `buttons[23:2]` are ignored.
- `bits`, output, 8: current pattern, registered.

## Operation

Input conditioning (`buttons[1:0]` only):
- Two-flop synchronizer: `s1 <= buttons[1:0]`, `s2 <= s1`.
- Previous-value flop: `prev <= s2`.
- Press event: `rise = s2 & ~prev`, per button.

Pattern update, evaluated each clock while `reset` = 0:
- `rise[0]` only, and `bits[0]` = 0: `bits <= bits >> 1`, zero-filled at MSB.
- `rise[0]` only, and `bits[0]` = 1: no change (right saturation).
- `rise[1]` only, and `bits[7]` = 0: `bits <= bits << 1`, zero-filled at LSB.
- `rise[1]` only, and `bits[7]` = 1: no change (left saturation).
- Both rises in the same cycle: no change.
- Neither rise: hold.

Conditioning behaviour:
- Holding a button produces exactly one shift. A new shift requires release (`s2` = 0 for at least one cycle) followed by a fresh press.
- The pattern is never rotated, and set bits are never discarded.
- With `START_BITS` = 0, all shifts leave `bits` at 0.

Reset:
- `bits <= START_BITS`.
- `s1`, `s2` and `prev` are all cleared to 0.
- A button already held when reset deasserts counts as one press once it reaches `s2`.
- Reset mid-operation discards any pending press in the synchronizer.

## Timing

- Latency: a button level first sampled high at rising edge k updates `bits` at edge k+2.
- Minimum pulse: a button must be high for at least one full clock period to be registered.
- Minimum gap: a button must be low for at least one full clock period between presses.
- Throughput: at most one shift per button press, and at most one shift per clock.
- `bits` is a plain register output with no combinational path from `buttons`.
- While `reset` = 1, `bits` = `START_BITS` from the first clock edge on which reset is sampled high.

## Test plan

- Reset: assert `reset` for 2 cycles with default `START_BITS` -> `bits` = `8'b00011000`, and stays there with no buttons pressed.
- Right saturation: after reset, apply 10 presses of `buttons[0]`, each 5 cycles high / 5 cycles low -> `bits` steps 00001100, 00000110, 00000011, then stays `8'b00000011`.
- Left saturation: from `8'b00000011`, apply 10 presses of `buttons[1]`, same pulse shape -> `bits` = `8'b11000000`, reached after the 6th press and unchanged for the remaining 4.
- Hold behaviour: from `8'b00011000`, hold `buttons[1]` high for 50 cycles -> exactly one shift, giving `8'b00110000`; the shift appears 2 cycles after the first sampled-high edge.
- Simultaneous and ignored inputs:
  - Raise `buttons[0]` and `buttons[1]` on the same edge -> `bits` unchanged.
  - Toggle `buttons[23:2]` in any pattern -> `bits` unchanged.
- Reset mid-operation:
  - Assert `reset` one cycle after pressing `buttons[0]` -> `bits` = `START_BITS` with no shift applied.
  - Override `START_BITS` = `8'b10000000`, then press `buttons[1]` -> `bits` stays `8'b10000000`.

Source files
------------

// File: rtl/bit_shift_ctrl.sv
// Button-driven 8-bit LED shift register; edges saturate instead of rotating.
// Latency: button sampled high at edge k moves bits at edge k+2.
// Backpressure: none; one shift per press, extra presses at an edge are dropped.
module bit_shift_ctrl #(
    parameter logic [7:0] START_BITS = 8'b00011000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] buttons,
    output logic [7:0]  bits
);

    logic [1:0] s1_q, s2_q, prev_q;
    logic [1:0] rise;
    logic [7:0] bits_q, bits_d;

    // Only the two shift buttons are wired; the rest of the row is reserved.
    logic unused_buttons;
    assign unused_buttons = ^buttons[23:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= 2'b00;
            s2_q   <= 2'b00;
            prev_q <= 2'b00;
            bits_q <= START_BITS;
        end else begin
            s1_q   <= buttons[1:0];
            s2_q   <= s1_q;
            prev_q <= s2_q;
            bits_q <= bits_d;
        end
    end

    always_comb begin
        bits_d = bits_q;
        rise   = s2_q & ~prev_q;
        // A shift that would drop a set bit is suppressed, as is a double press.
        case (rise)
            2'b01:   if (!bits_q[0]) bits_d = bits_q >> 1;
            2'b10:   if (!bits_q[7]) bits_d = bits_q << 1;
            default: bits_d = bits_q;
        endcase
    end

    assign bits = bits_q;

endmodule

// File: tb/tb_bit_shift_ctrl.sv
// Directed bench for bit_shift_ctrl: default instance plus one with START_BITS=8'b10000000.
module tb_bit_shift_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] buttons_a, buttons_b;
    logic [7:0]  bits_a, bits_b;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    bit_shift_ctrl dut_a (
        .clk     (clk),
        .reset   (reset),
        .buttons (buttons_a),
        .bits    (bits_a)
    );

    bit_shift_ctrl #(.START_BITS(8'b10000000)) dut_b (
        .clk     (clk),
        .reset   (reset),
        .buttons (buttons_b),
        .bits    (bits_b)
    );

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic press_a(input int idx);
        buttons_a[idx] = 1'b1;
        tick(5);
        buttons_a[idx] = 1'b0;
        tick(5);
    endtask

    logic [7:0] right_exp [10];
    logic [7:0] left_exp  [10];

    initial begin
        right_exp = '{8'h0C, 8'h06, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03};
        left_exp  = '{8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};

        reset     = 1'b1;
        buttons_a = '0;
        buttons_b = '0;
        tick(2);
        check("reset_a", bits_a, 8'b00011000);
        check("reset_b", bits_b, 8'b10000000);
        reset = 1'b0;
        tick(5);
        check("idle_hold", bits_a, 8'b00011000);

        for (int i = 0; i < 10; i++) begin
            press_a(0);
            check($sformatf("right_press%0d", i + 1), bits_a, right_exp[i]);
        end

        for (int i = 0; i < 10; i++) begin
            press_a(1);
            check($sformatf("left_press%0d", i + 1), bits_a, left_exp[i]);
        end

        // Hold: first sampled-high edge k, shift visible at k+2.
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        check("hold_pre", bits_a, 8'b00011000);
        buttons_a[1] = 1'b1;
        tick(1);
        check("hold_k", bits_a, 8'b00011000);
        tick(1);
        check("hold_k1", bits_a, 8'b00011000);
        tick(1);
        check("hold_k2", bits_a, 8'b00110000);
        tick(47);
        check("hold_50", bits_a, 8'b00110000);
        buttons_a[1] = 1'b0;
        tick(5);
        check("hold_release", bits_a, 8'b00110000);

        buttons_a[1:0] = 2'b11;
        tick(10);
        check("both_pressed", bits_a, 8'b00110000);
        buttons_a[1:0] = 2'b00;
        tick(5);
        check("both_released", bits_a, 8'b00110000);

        for (int i = 0; i < 8; i++) begin
            buttons_a[23:2] = (i % 2 == 0) ? 22'h3FFFFF : 22'h155555 << (i % 3);
            tick(3);
        end
        buttons_a[23:2] = '0;
        tick(5);
        check("ignored_bits", bits_a, 8'b00110000);

        // Reset one cycle into a press discards it.
        buttons_a[0] = 1'b1;
        tick(1);
        reset        = 1'b1;
        buttons_a[0] = 1'b0;
        tick(1);
        check("midreset_during", bits_a, 8'b00011000);
        tick(1);
        reset = 1'b0;
        tick(6);
        check("midreset_after", bits_a, 8'b00011000);

        // A button held across reset release counts as one press.
        reset        = 1'b1;
        buttons_a[0] = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(6);
        check("held_through_reset", bits_a, 8'b00001100);
        buttons_a[0] = 1'b0;
        tick(5);

        buttons_b[1] = 1'b1;
        tick(5);
        buttons_b[1] = 1'b0;
        tick(5);
        check("b_left_saturate", bits_b, 8'b10000000);
        buttons_b[0] = 1'b1;
        tick(5);
        buttons_b[0] = 1'b0;
        tick(5);
        check("b_right_shift", bits_b, 8'b01000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
